// File: rtl/imem_boot_seq.sv
// Boot sequencer: streams a program into instruction memory, holds the datapath
// in reset, runs it for a fixed budget, then signals end of simulation.
module imem_boot_seq #(
    parameter logic [31:0] IMEM_BASE  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 1024,
    parameter int          RST_HOLD   = 4,
    parameter int          RUN_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    input  logic        src_eof,
    output logic        src_rd_en,
    output logic        imem_wr_n,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic [31:0] pc,
    output logic        dut_rst,
    output logic        end_sim,
    output logic [31:0] word_count,
    output logic        load_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
    localparam logic [31:0] RUN_LAST  = 32'(RUN_CYCLES - 1);

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [31:0] cnt;
    logic        accept;
    logic        full;
    logic        wr;

    always_comb begin
        accept = (state == S_LOAD) && src_valid;
        full   = (word_count == MAX_W);
        wr     = accept && !full;
    end

    // The address port belongs to the processor only while it runs.
    assign src_rd_en = (state == S_LOAD);
    assign dut_rst   = (state != S_RUN);
    assign imem_addr = (state == S_RUN) ? pc : addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= IMEM_BASE;
            imem_wdata <= 32'h0;
            imem_wr_n  <= 1'b1;
            word_count <= 32'h0;
            load_err   <= 1'b0;
            end_sim    <= 1'b0;
            cnt        <= 32'h0;
        end else begin
            imem_wr_n <= 1'b1;
            case (state)
                S_IDLE: state <= S_LOAD;
                S_LOAD: begin
                    if (wr) begin
                        addr_q     <= IMEM_BASE + (word_count << 2);
                        imem_wdata <= src_data;
                        imem_wr_n  <= 1'b0;
                        word_count <= word_count + 32'd1;
                    end
                    // Overflow takes priority over a coincident end-of-file.
                    if (accept && full) begin
                        load_err <= 1'b1;
                        end_sim  <= 1'b1;
                        state    <= S_DONE;
                    end else if (src_eof) begin
                        if (wr || (word_count != 32'h0)) begin
                            state <= S_HOLD;
                            cnt   <= 32'h0;
                        end else begin
                            load_err <= 1'b1;
                            end_sim  <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_RUN;
                        cnt   <= 32'h0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    if (cnt == RUN_LAST) begin
                        state   <= S_DONE;
                        end_sim <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_seq.sv
// Directed bench for imem_boot_seq: load, hold, run timeout, overflow/empty
// error paths and reset during run.
module tb_imem_boot_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_eof;
    logic        src_rd_en;
    logic        imem_wr_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic        dut_rst;
    logic        end_sim;
    logic [31:0] word_count;
    logic        load_err;

    int total = 0;
    int bad = 0;
    int wr_pulses = 0;
    int rst_low = 0;
    int pulse_base = 0;

    always #5 clk = ~clk;

    imem_boot_seq #(
        .IMEM_BASE (32'h0000_0000),
        .MAX_WORDS (4),
        .RST_HOLD  (4),
        .RUN_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_eof   (src_eof),
        .src_rd_en (src_rd_en),
        .imem_wr_n (imem_wr_n),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .pc        (pc),
        .dut_rst   (dut_rst),
        .end_sim   (end_sim),
        .word_count(word_count),
        .load_err  (load_err)
    );

    always @(negedge clk) begin
        if (imem_wr_n === 1'b0) wr_pulses <= wr_pulses + 1;
        if (dut_rst === 1'b0) rst_low <= rst_low + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; src_valid = 1'b0; src_eof = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; src_valid = 1'b0; src_eof = 1'b0; src_data = 32'h0; pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({src_rd_en, imem_wr_n, dut_rst, end_sim, load_err} !== 5'b01100) begin
                bad++; $display("FAIL reset_ctl got=%b exp=01100", {src_rd_en, imem_wr_n, dut_rst, end_sim, load_err});
            end
            total++;
            if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
            total++;
            if (imem_wdata !== 32'h0 || word_count !== 32'h0) begin
                bad++; $display("FAIL reset_data got=%h/%0d exp=0/0", imem_wdata, word_count);
            end
        end
        rst = 1'b0;
        total++;
        if (src_rd_en !== 1'b0) begin bad++; $display("FAIL rd_en_idle got=%b exp=0", src_rd_en); end
        step();
        total++;
        if (src_rd_en !== 1'b1) begin bad++; $display("FAIL rd_en_load got=%b exp=1", src_rd_en); end
    endtask

    task automatic test_load_gap();
        pulse_base = wr_pulses;
        src_valid = 1'b1; src_data = 32'h00500093; step();
        total++;
        if (imem_wr_n !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h00500093) begin
            bad++; $display("FAIL load_w0 got=%b/%h/%h exp=0/00000000/00500093", imem_wr_n, imem_addr, imem_wdata);
        end
        src_data = 32'h00A00113; step();
        total++;
        if (imem_wr_n !== 1'b0 || imem_addr !== 32'h4 || imem_wdata !== 32'h00A00113) begin
            bad++; $display("FAIL load_w1 got=%b/%h/%h exp=0/00000004/00a00113", imem_wr_n, imem_addr, imem_wdata);
        end
        src_valid = 1'b0; step();
        total++;
        if (imem_wr_n !== 1'b1 || imem_addr !== 32'h4 || word_count !== 32'd2) begin
            bad++; $display("FAIL load_gap got=%b/%h/%0d exp=1/00000004/2", imem_wr_n, imem_addr, word_count);
        end
        src_valid = 1'b1; src_data = 32'h002081B3; src_eof = 1'b1; step();
        src_valid = 1'b0; src_eof = 1'b0;
        total++;
        if (imem_wr_n !== 1'b0 || imem_addr !== 32'h8 || imem_wdata !== 32'h002081B3) begin
            bad++; $display("FAIL load_w2 got=%b/%h/%h exp=0/00000008/002081b3", imem_wr_n, imem_addr, imem_wdata);
        end
        total++;
        if (word_count !== 32'd3) begin bad++; $display("FAIL load_count got=%0d exp=3", word_count); end
    endtask

    task automatic test_hold_handover();
        pc = 32'h10;
        total++;
        if (dut_rst !== 1'b1 || src_rd_en !== 1'b0) begin
            bad++; $display("FAIL hold_first got=%b/%b exp=1/0", dut_rst, src_rd_en);
        end
        for (int i = 2; i <= 4; i++) begin
            step();
            total++;
            if (dut_rst !== 1'b1) begin bad++; $display("FAIL hold_cycle%0d got=%b exp=1", i, dut_rst); end
        end
        step();
        total++;
        if (dut_rst !== 1'b0 || imem_addr !== 32'h10 || imem_wr_n !== 1'b1) begin
            bad++; $display("FAIL run_first got=%b/%h/%b exp=0/00000010/1", dut_rst, imem_addr, imem_wr_n);
        end
        pc = 32'h24; #1;
        total++;
        if (imem_addr !== 32'h24) begin bad++; $display("FAIL pc_pass got=%h exp=00000024", imem_addr); end
        total++;
        if (wr_pulses - pulse_base !== 3) begin
            bad++; $display("FAIL load_pulses got=%0d exp=3", wr_pulses - pulse_base);
        end
    endtask

    task automatic test_run_timeout();
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (end_sim !== 1'b0 || dut_rst !== 1'b0) begin
                bad++; $display("FAIL run_cycle%0d got=%b/%b exp=0/0", k, end_sim, dut_rst);
            end
            step();
        end
        total++;
        if (end_sim !== 1'b1 || dut_rst !== 1'b1 || src_rd_en !== 1'b0 || imem_wr_n !== 1'b1) begin
            bad++; $display("FAIL done_entry got=%b/%b/%b/%b exp=1/1/0/1", end_sim, dut_rst, src_rd_en, imem_wr_n);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (end_sim !== 1'b1 || dut_rst !== 1'b1) begin
                bad++; $display("FAIL done_sticky%0d got=%b/%b exp=1/1", k, end_sim, dut_rst);
            end
        end
    endtask

    task automatic test_overflow();
        int pb;
        int rb;
        do_reset();
        pb = wr_pulses; rb = rst_low;
        for (int i = 0; i < 5; i++) begin
            src_valid = 1'b1; src_data = 32'hC0DE_0000 + 32'(i); step();
            if (i < 4) begin
                total++;
                if (imem_wr_n !== 1'b0 || imem_addr !== 32'(4 * i) || imem_wdata !== 32'hC0DE_0000 + 32'(i)) begin
                    bad++; $display("FAIL ovf_w%0d got=%b/%h/%h exp=0/%h/%h", i, imem_wr_n, imem_addr, imem_wdata,
                                    32'(4 * i), 32'hC0DE_0000 + 32'(i));
                end
            end
        end
        src_valid = 1'b0;
        total++;
        if (imem_wr_n !== 1'b1 || load_err !== 1'b1 || end_sim !== 1'b1 || word_count !== 32'd4 || src_rd_en !== 1'b0) begin
            bad++; $display("FAIL ovf_err got=%b/%b/%b/%0d/%b exp=1/1/1/4/0", imem_wr_n, load_err, end_sim, word_count, src_rd_en);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (dut_rst !== 1'b1 || load_err !== 1'b1) begin
                bad++; $display("FAIL ovf_hold%0d got=%b/%b exp=1/1", k, dut_rst, load_err);
            end
        end
        total++;
        if (wr_pulses - pb !== 4) begin bad++; $display("FAIL ovf_pulses got=%0d exp=4", wr_pulses - pb); end
        total++;
        if (rst_low !== rb) begin bad++; $display("FAIL ovf_rst_low got=%0d exp=0", rst_low - rb); end
    endtask

    task automatic test_empty();
        int pb;
        do_reset();
        pb = wr_pulses;
        src_eof = 1'b1; step();
        src_eof = 1'b0;
        total++;
        if (load_err !== 1'b1 || end_sim !== 1'b1 || src_rd_en !== 1'b0 || word_count !== 32'h0 || dut_rst !== 1'b1) begin
            bad++; $display("FAIL empty_err got=%b/%b/%b/%0d/%b exp=1/1/0/0/1", load_err, end_sim, src_rd_en, word_count, dut_rst);
        end
        step(); step(); step();
        total++;
        if (wr_pulses !== pb) begin bad++; $display("FAIL empty_pulses got=%0d exp=0", wr_pulses - pb); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        src_valid = 1'b1; src_data = 32'h1111_1111; src_eof = 1'b1; step();
        src_valid = 1'b0; src_eof = 1'b0;
        pc = 32'h24;
        for (int k = 0; k < 6; k++) step();
        total++;
        if (dut_rst !== 1'b0 || imem_addr !== 32'h24) begin
            bad++; $display("FAIL mid_running got=%b/%h exp=0/00000024", dut_rst, imem_addr);
        end
        rst = 1'b1; step();
        total++;
        if ({src_rd_en, imem_wr_n, dut_rst, end_sim, load_err} !== 5'b01100 || imem_addr !== 32'h0 || word_count !== 32'h0) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%0d exp=01100/00000000/0",
                            {src_rd_en, imem_wr_n, dut_rst, end_sim, load_err}, imem_addr, word_count);
        end
        rst = 1'b0; step();
        total++;
        if (src_rd_en !== 1'b1) begin bad++; $display("FAIL mid_reload_rd got=%b exp=1", src_rd_en); end
        src_valid = 1'b1; src_data = 32'hAAAA_0001; step();
        total++;
        if (imem_wr_n !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'hAAAA_0001) begin
            bad++; $display("FAIL mid_w0 got=%b/%h/%h exp=0/00000000/aaaa0001", imem_wr_n, imem_addr, imem_wdata);
        end
        src_data = 32'hAAAA_0002; src_eof = 1'b1; step();
        src_valid = 1'b0; src_eof = 1'b0;
        total++;
        if (imem_wr_n !== 1'b0 || imem_addr !== 32'h4 || imem_wdata !== 32'hAAAA_0002) begin
            bad++; $display("FAIL mid_w1 got=%b/%h/%h exp=0/00000004/aaaa0002", imem_wr_n, imem_addr, imem_wdata);
        end
        total++;
        if (word_count !== 32'd2 || end_sim !== 1'b0) begin
            bad++; $display("FAIL mid_count got=%0d/%b exp=2/0", word_count, end_sim);
        end
    endtask

    initial begin
        test_reset();
        test_load_gap();
        test_hold_handover();
        test_run_timeout();
        test_overflow();
        test_empty();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
